// File: rtl/rr_onehot_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Holds the arbiter state encoding and the grant-index width rule.
package rr_onehot_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_e;

  // Width of a binary index into N requesters; never narrower than one bit.
  function automatic int rr_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority select: first set req bit at or after ptr, wrapping N-1 -> 0.
// Purely combinational.
module rr_pick
  import rr_onehot_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  int c;

  // Scan offsets from farthest to nearest so the closest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_onehot_arb.sv
// Two-state round-robin arbiter with registered one-hot grant.
// A grant is held until done or withdrawal, then one IDLE cycle always follows.
module rr_onehot_arb
  import rr_onehot_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = rr_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  if (N < 2) begin : g_bad_n
    $error("rr_onehot_arb: N must be at least 2");
  end

  rr_state_e     state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          release_now;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign release_now = done | ~req[gnt_idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release always lands in IDLE with cleared outputs, so grants never abut.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d       = N'(1) << pick_idx;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
        end else begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d       = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = '0;
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Directed scoreboard bench for rr_onehot_arb at N=4 and N=3.
// Expected grants are queued at drive time and popped after the following edge.
module tb_rr_onehot_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req4 = '0;
  logic       done4 = 1'b0;
  logic [3:0] gnt4;
  logic       vld4;
  logic [1:0] idx4;
  logic [2:0] req3 = '0;
  logic       done3 = 1'b0;
  logic [2:0] gnt3;
  logic       vld3;
  logic [1:0] idx3;

  int total = 0;
  int bad   = 0;

  logic [3:0] q4[$];
  logic [2:0] q3[$];

  always #5 clk = ~clk;

  rr_onehot_arb #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .done(done4),
    .gnt(gnt4), .gnt_valid(vld4), .gnt_idx(idx4)
  );

  rr_onehot_arb #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .done(done3),
    .gnt(gnt3), .gnt_valid(vld3), .gnt_idx(idx3)
  );

  function automatic int idx_of(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc4(input logic [3:0] r, input logic d, input logic [3:0] e);
    logic [3:0] ev;
    @(negedge clk);
    req4 = r;
    done4 = d;
    q4.push_back(e);
    @(posedge clk);
    #1;
    ev = q4.pop_front();
    chk("gnt4", int'(gnt4), int'(ev));
    chk("vld4", int'(vld4), int'(ev != 4'b0));
    chk("idx4", int'(idx4), idx_of(ev));
  endtask

  task automatic cyc3(input logic [2:0] r, input logic d, input logic [2:0] e);
    logic [2:0] ev;
    @(negedge clk);
    req3 = r;
    done3 = d;
    q3.push_back(e);
    @(posedge clk);
    #1;
    ev = q3.pop_front();
    chk("gnt3", int'(gnt3), int'(ev));
    chk("vld3", int'(vld3), int'(ev != 3'b0));
    chk("idx3", int'(idx3), idx_of({1'b0, ev}));
  endtask

  // Structural properties of the N=3 instance, checked every active cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      assert (!vld3 || $onehot(gnt3)) else begin
        bad++;
        $error("FAIL onehot3 observed=%b expected=onehot", gnt3);
      end
      total++;
      assert (dut3.ptr_q < 2'd3) else begin
        bad++;
        $error("FAIL ptr3_range observed=%0d expected=<3", dut3.ptr_q);
      end
      total++;
      assert (vld3 === (gnt3 != 3'b0)) else begin
        bad++;
        $error("FAIL vld3_match observed=%b expected=%b", vld3, gnt3 != 3'b0);
      end
    end
  end

  initial begin
    #12;
    chk("rst_gnt4", int'(gnt4), 0);
    chk("rst_vld4", int'(vld4), 0);
    chk("rst_idx4", int'(idx4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester then release
    cyc4(4'b0100, 1'b0, 4'b0100);
    cyc4(4'b0100, 1'b0, 4'b0100);
    cyc4(4'b0100, 1'b1, 4'b0000);
    chk("ptr_after_single", int'(dut4.ptr_q), 3);

    // Wrap and skip from ptr=3
    cyc4(4'b0011, 1'b0, 4'b0001);
    cyc4(4'b0011, 1'b1, 4'b0000);
    chk("ptr_after_wrap", int'(dut4.ptr_q), 1);
    cyc4(4'b0011, 1'b0, 4'b0010);

    // Withdraw without done
    cyc4(4'b0001, 1'b0, 4'b0000);
    chk("ptr_after_withdraw", int'(dut4.ptr_q), 2);

    // No preemption, then done and withdraw at the same edge
    cyc4(4'b0100, 1'b0, 4'b0100);
    cyc4(4'b1111, 1'b0, 4'b0100);
    cyc4(4'b1011, 1'b1, 4'b0000);
    chk("ptr_single_release", int'(dut4.ptr_q), 3);
    cyc4(4'b0000, 1'b0, 4'b0000);
    cyc4(4'b0000, 1'b1, 4'b0000);
    chk("ptr_done_in_idle", int'(dut4.ptr_q), 3);

    // Asynchronous reset mid-grant
    cyc4(4'b1000, 1'b0, 4'b1000);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req4 = 4'b0000;
    #1;
    chk("async_rst_gnt", int'(gnt4), 0);
    chk("async_rst_vld", int'(vld4), 0);
    chk("async_rst_ptr", int'(dut4.ptr_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc4(4'b1001, 1'b0, 4'b0001);
    cyc4(4'b1001, 1'b1, 4'b0000);

    // Rotation from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    req4 = 4'b0000;
    done4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc4(4'b1111, 1'b0, 4'b0001);
    cyc4(4'b1111, 1'b1, 4'b0000);
    cyc4(4'b1111, 1'b0, 4'b0010);
    cyc4(4'b1111, 1'b1, 4'b0000);
    cyc4(4'b1111, 1'b0, 4'b0100);
    cyc4(4'b1111, 1'b1, 4'b0000);
    cyc4(4'b1111, 1'b0, 4'b1000);
    cyc4(4'b1111, 1'b1, 4'b0000);
    cyc4(4'b1111, 1'b0, 4'b0001);
    cyc4(4'b0000, 1'b1, 4'b0000);

    // Non-power-of-two rotation
    cyc3(3'b111, 1'b0, 3'b001);
    cyc3(3'b111, 1'b1, 3'b000);
    cyc3(3'b111, 1'b0, 3'b010);
    cyc3(3'b111, 1'b1, 3'b000);
    cyc3(3'b111, 1'b0, 3'b100);
    cyc3(3'b111, 1'b1, 3'b000);
    chk("ptr3_wrap", int'(dut3.ptr_q), 0);
    cyc3(3'b111, 1'b0, 3'b001);
    cyc3(3'b000, 1'b0, 3'b000);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arb.md
RR_ONEHOT_ARB -- requirements
Module: rr_onehot_arb

Interface
REQ-001: Parameter N, default 4, number of requesters; the block SHALL reject N < 2 at elaboration.
REQ-002: Parameter IW, default $clog2(N), width of the grant index.
REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous and active-low.
REQ-005: req  input  N  request vector; bit i high means requester i wants the resource.
REQ-006: done  input  1  single-cycle pulse from the current owner releasing the grant.
REQ-007: gnt  output  N  registered grant vector, either all-zero or exactly one bit set.
REQ-008: gnt_valid  output  1  registered; high exactly when gnt is nonzero.
REQ-009: gnt_idx  output  IW  registered binary index of the set gnt bit; 0 when gnt_valid is low.

Function
REQ-010: The block SHALL be an FSM with exactly two states: IDLE and GRANT.
REQ-011: IDLE, req nonzero: the block SHALL select the first set req bit at or after pointer ptr, wrapping from N-1 to 0, and enter GRANT.
REQ-012: On that entry, gnt, gnt_valid and gnt_idx SHALL assert in the cycle after the sampling edge, giving one-cycle latency.
REQ-013: IDLE, req all-zero: the block SHALL stay in IDLE with gnt=0, gnt_valid=0 and gnt_idx=0.
REQ-014: GRANT: gnt SHALL stay constant while done=0 and req[gnt_idx]=1; requests from other requesters SHALL NOT preempt it.
REQ-015: GRANT, done=1 or req[gnt_idx]=0 at an edge: the block SHALL return to IDLE, clear gnt, gnt_valid and gnt_idx, and set ptr to (gnt_idx+1) mod N.
REQ-016: After every release the block SHALL spend at least one cycle in IDLE before the next grant; no back-to-back grants.
REQ-017: done sampled in IDLE SHALL be ignored.
REQ-018: If done=1 and req[gnt_idx]=0 at the same edge, the block SHALL perform a single release only.
REQ-019: ptr SHALL be IW bits wide.
REQ-020: The (gnt_idx+1) mod N wrap SHALL be correct for non-power-of-two N; ptr SHALL never hold a value of N or greater.
REQ-021: gnt SHALL equal 1 shifted left by gnt_idx whenever gnt_valid=1.
REQ-022: Every output SHALL come directly from a flop, with no combinational path from req or done to any output.

Reset
REQ-023: rst_n low SHALL immediately force state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0 and ptr=0, independent of clk.
REQ-024: Reset asserted during GRANT SHALL drop the grant asynchronously and discard the owner; no rotation SHALL be recorded.
REQ-025: After reset deasserts, the first arbitration SHALL take place at the first rising edge with rst_n high, starting from ptr=0.

Structure
REQ-026: The FSM state enum (IDLE, GRANT) SHALL reside in shared package rr_onehot_pkg.
REQ-027: The index-width helper constant for IW SHALL also reside in rr_onehot_pkg.
REQ-028: The rotating priority select SHALL be a combinational sub-module, rr_pick, with ports req, ptr, found and idx.
REQ-029: rr_onehot_arb SHALL contain only the FSM, ptr and the output registers.
REQ-030: The exactly-one-bit property of gnt SHALL be checkable by the team's existing one-hot checker module attached to gnt in the bench.

Verification (N=4 unless noted)
REQ-031: Single requester: req=0100 from reset -> next cycle gnt=0100, gnt_idx=2; done pulse -> gnt=0000, ptr=3.
REQ-032: Rotation: req=1111 held, done pulsed each grant -> grant order 0001, 0010, 0100, 1000, 0001, each grant separated by one IDLE cycle.
REQ-033: Wrap and skip: ptr=3, req=0011 -> gnt=0001; after release, req=0011 -> gnt=0010.
REQ-034: Withdraw: granted 0010, req[1] drops with done=0 -> gnt=0000 next cycle, ptr=2; done=1 arriving at the same edge -> still a single release.
REQ-035: Reset mid-grant: gnt=1000, rst_n pulsed low between edges -> gnt=0000 before the next edge; after reset, req=1001 -> gnt=0001.
REQ-036: N=3: req=111 with repeated releases -> order 001, 010, 100, 001; ptr never equals 3; the one-hot checker passes on every cycle with gnt_valid=1.
